// File: rtl/p405s_pdp_rdq_pkg.sv
// Shared sizing helpers and defaults for the PDP read-drain queue.
// Pointer width is ceil(log2(DEPTH)); Count needs one extra bit to hold DEPTH itself.
package p405s_pdp_rdq_pkg;

  localparam int N_DEF     = 10;
  localparam int DEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int count_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/p405s_pdp_rdq_mem.sv
// DEPTH x N storage for the drain queue: one synchronous write port, asynchronous read.
// No reset: contents are meaningless until written.
module p405s_pdp_rdq_mem
  import p405s_pdp_rdq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [0:N-1]              wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [0:N-1]              rdata
);

  logic [0:N-1] mem_reg [DEPTH];

  // The ternary (rather than if) lets an unknown write enable poison the target entry.
  always_ff @(posedge clk) begin
    mem_reg[waddr] <= we ? wdata : mem_reg[waddr];
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/p405s_pdp_rdq_drain.sv
// In-order drain queue behind the enable-gated PDP write ports (valid/ack consumer side).
// Optional macro P405S_PDP_RDQ_BYPASS_EN: presents D combinationally when the queue is empty.
module p405s_pdp_rdq_drain
  import p405s_pdp_rdq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         CB,
  input  logic                         RST,
  input  logic                         E1,
  input  logic [0:N-1]                 D,
  output logic                         RdVal,
  input  logic                         RdAck,
  output logic [0:N-1]                 RdData,
  output logic                         Full,
  output logic                         Empty,
  output logic [0:count_w(DEPTH)-1]    Count,
  output logic                         Ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;

  logic [0:N-1]  mem_rdata;
  logic          empty;
  logic          full;
  logic          rd_val;
  logic [0:N-1]  rd_data;
  logic          pop;
  logic          byp_take;
  logic          push_q;
  logic          pop_q;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  always_comb begin
    rd_val   = ~empty;
    rd_data  = empty ? '0 : mem_rdata;
    byp_take = 1'b0;
`ifdef P405S_PDP_RDQ_BYPASS_EN
    if (empty && E1) begin
      rd_val  = 1'b1;
      rd_data = D;
    end
    byp_take = empty & E1 & RdAck;
`endif
  end

  // A bypassed word is consumed on the fly, so neither pointer nor Count moves.
  assign pop    = rd_val & RdAck;
  assign push_q = E1 & (~full | pop) & ~byp_take;
  assign pop_q  = pop & ~byp_take;

  // Arithmetic updates (not if-guards) so an X on E1 spreads into pointers and Count.
  always_ff @(posedge CB or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_q);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_q);
      count_reg  <= count_reg + CW'(push_q) - CW'(pop_q);
      ovf_reg    <= ovf_reg | (full & E1 & ~pop);
    end
  end

  p405s_pdp_rdq_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CB),
    .we    (push_q),
    .waddr (wr_ptr_reg),
    .wdata (D),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign RdVal  = rd_val;
  assign RdData = rd_data;
  assign Full   = full;
  assign Empty  = empty;
  assign Count  = count_reg;
  assign Ovf    = ovf_reg;

endmodule
